// File: rtl/vga_timing_pkg.sv
// Shared types and default 1280x1024@60 geometry for the VGA timing generator.
package vga_timing_pkg;

  localparam int unsigned COORD_W = 16;

  typedef enum logic [1:0] {
    PH_ACTIVE,
    PH_FRONT,
    PH_SYNC,
    PH_BACK
  } phase_t;

  localparam int unsigned DEF_H_ACTIVE = 1280;
  localparam int unsigned DEF_H_FP     = 48;
  localparam int unsigned DEF_H_SYNC   = 112;
  localparam int unsigned DEF_H_BP     = 248;

  localparam int unsigned DEF_V_ACTIVE = 1024;
  localparam int unsigned DEF_V_FP     = 1;
  localparam int unsigned DEF_V_SYNC   = 3;
  localparam int unsigned DEF_V_BP     = 38;

  function automatic phase_t phase_succ(input phase_t p);
    phase_t n;
    n = PH_ACTIVE;
    case (p)
      PH_ACTIVE: n = PH_FRONT;
      PH_FRONT:  n = PH_SYNC;
      PH_SYNC:   n = PH_BACK;
      PH_BACK:   n = PH_ACTIVE;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/vga_timing_gen_axis.sv
// One raster axis: position counter plus ACTIVE/FRONT/SYNC/BACK phase FSM with registered sync.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned FP     = DEF_H_FP,
  parameter int unsigned SYNC   = DEF_H_SYNC,
  parameter int unsigned BP     = DEF_H_BP,
  parameter bit          POL    = 1'b1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_step,
  output logic [COORD_W-1:0] count,
  output phase_t             phase_nxt,
  output logic               sync,
  output logic               wrap
);

  localparam int unsigned         TOTAL = ACTIVE + FP + SYNC + BP;
  localparam logic [COORD_W-1:0]  LAST  = COORD_W'(TOTAL - 1);

  phase_t             phase;
  logic [COORD_W-1:0] seg_cnt;
  logic [COORD_W-1:0] seg_cnt_nxt;
  logic [COORD_W-1:0] seg_last;
  logic [COORD_W-1:0] count_nxt;
  logic               seg_end;

  // Segment boundaries come from the phase state, so no wide comparators on count.
  always_comb begin
    seg_last = '0;
    case (phase)
      PH_ACTIVE: seg_last = COORD_W'(ACTIVE - 1);
      PH_FRONT:  seg_last = COORD_W'(FP - 1);
      PH_SYNC:   seg_last = COORD_W'(SYNC - 1);
      PH_BACK:   seg_last = COORD_W'(BP - 1);
    endcase

    seg_end     = (seg_cnt == seg_last);
    wrap        = (phase == PH_BACK) && seg_end;
    count_nxt   = count;
    seg_cnt_nxt = seg_cnt;
    phase_nxt   = phase;

    if (i_step) begin
      count_nxt = wrap ? '0 : count + COORD_W'(1);
      if (seg_end) begin
        seg_cnt_nxt = '0;
        phase_nxt   = phase_succ(phase);
      end else begin
        seg_cnt_nxt = seg_cnt + COORD_W'(1);
      end
    end
  end

  // Reset parks the axis on the last pixel of BACK so the first step lands on 0.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      count   <= LAST;
      phase   <= PH_BACK;
      seg_cnt <= COORD_W'(BP - 1);
      sync    <= ~POL;
    end else begin
      count   <= count_nxt;
      phase   <= phase_nxt;
      seg_cnt <= seg_cnt_nxt;
      sync    <= (phase_nxt == PH_SYNC) ? POL : ~POL;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing source: coordinates, syncs, active flag, line/frame strobes.
// Optional frame counter enabled by defining VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
  parameter int unsigned H_FP       = DEF_H_FP,
  parameter int unsigned H_SYNC     = DEF_H_SYNC,
  parameter int unsigned H_BP       = DEF_H_BP,
  parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
  parameter int unsigned V_FP       = DEF_V_FP,
  parameter int unsigned V_SYNC     = DEF_V_SYNC,
  parameter int unsigned V_BP       = DEF_V_BP,
  parameter bit          H_SYNC_POL = 1'b1,
  parameter bit          V_SYNC_POL = 1'b1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_pix_en,
  output logic [COORD_W-1:0] o_x,
  output logic [COORD_W-1:0] o_y,
  output logic               o_h_sync,
  output logic               o_v_sync,
  output logic               o_active,
  output logic               o_line_start,
  output logic               o_frame_start,
  output logic [COORD_W-1:0] o_frame_count
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 || H_TOTAL > 65535) begin : g_bad_h
    $error("vga_timing_gen: illegal horizontal geometry");
  end
  if (V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 || V_TOTAL > 65535) begin : g_bad_v
    $error("vga_timing_gen: illegal vertical geometry");
  end

  phase_t h_phase_nxt;
  phase_t v_phase_nxt;
  logic   h_wrap;
  logic   v_wrap;
  logic   v_step;

  assign v_step = h_wrap & i_pix_en;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .POL    (H_SYNC_POL)
  ) u_h_axis (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_step    (i_pix_en),
    .count     (o_x),
    .phase_nxt (h_phase_nxt),
    .sync      (o_h_sync),
    .wrap      (h_wrap)
  );

  // V syncs only change on H wrap, so its edges always coincide with o_x becoming 0.
  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .POL    (V_SYNC_POL)
  ) u_v_axis (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_step    (v_step),
    .count     (o_y),
    .phase_nxt (v_phase_nxt),
    .sync      (o_v_sync),
    .wrap      (v_wrap)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_active      <= 1'b0;
      o_line_start  <= 1'b0;
      o_frame_start <= 1'b0;
    end else begin
      o_line_start  <= v_step;
      o_frame_start <= v_step & v_wrap;
      if (i_pix_en) begin
        o_active <= (h_phase_nxt == PH_ACTIVE) && (v_phase_nxt == PH_ACTIVE);
      end
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [COORD_W-1:0] frame_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      frame_cnt <= '0;
    end else if (v_step & v_wrap) begin
      frame_cnt <= frame_cnt + COORD_W'(1);
    end
  end

  assign o_frame_count = frame_cnt;
`else
  assign o_frame_count = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed self-checking bench: default 1280x1024 instance for line-level checks,
// a reduced-geometry instance (16x9 total, active-low syncs) for frame-level checks.
module tb_vga_timing_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        pix_en;

  logic [15:0] x, y, fc;
  logic        hs, vs, act, ls, fs;
  logic [15:0] sx, sy, sfc;
  logic        shs, svs, sact, sls, sfs;

  int checks = 0;
  int errors = 0;

  // Reference raster positions and expected strobes for both instances.
  int   bx, by, smx, smy;
  logic bls_e, bfs_e, sls_e, sfs_e;

  always #5 clk = ~clk;

  vga_timing_gen u_big (
    .i_clk(clk), .i_rst(rst), .i_pix_en(pix_en),
    .o_x(x), .o_y(y), .o_h_sync(hs), .o_v_sync(vs), .o_active(act),
    .o_line_start(ls), .o_frame_start(fs), .o_frame_count(fc)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0)
  ) u_small (
    .i_clk(clk), .i_rst(rst), .i_pix_en(pix_en),
    .o_x(sx), .o_y(sy), .o_h_sync(shs), .o_v_sync(svs), .o_active(sact),
    .o_line_start(sls), .o_frame_start(sfs), .o_frame_count(sfc)
  );

  task automatic model_reset();
    bx = 1687; by = 1065; smx = 15; smy = 8;
    bls_e = 1'b0; bfs_e = 1'b0; sls_e = 1'b0; sfs_e = 1'b0;
  endtask

  task automatic tick();
    logic en;
    en = pix_en;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else if (en) begin
      bls_e = (bx == 1687);
      bfs_e = bls_e && (by == 1065);
      if (bls_e) begin bx = 0; by = (by == 1065) ? 0 : by + 1; end
      else bx = bx + 1;
      sls_e = (smx == 15);
      sfs_e = sls_e && (smy == 8);
      if (sls_e) begin smx = 0; smy = (smy == 8) ? 0 : smy + 1; end
      else smx = smx + 1;
    end else begin
      bls_e = 1'b0; bfs_e = 1'b0; sls_e = 1'b0; sfs_e = 1'b0;
    end
    @(negedge clk);
  endtask

  function automatic int mism();
    int n = 0;
    if (x   !== 16'(bx))                      n++;
    if (y   !== 16'(by))                      n++;
    if (hs  !== (bx >= 1328 && bx <= 1439))   n++;
    if (vs  !== (by >= 1025 && by <= 1027))   n++;
    if (act !== (bx < 1280 && by < 1024))     n++;
    if (ls  !== bls_e)                        n++;
    if (fs  !== bfs_e)                        n++;
    if (sx   !== 16'(smx))                    n++;
    if (sy   !== 16'(smy))                    n++;
    if (shs  !== !(smx >= 10 && smx <= 12))   n++;
    if (svs  !== !(smy >= 5 && smy <= 6))     n++;
    if (sact !== (smx < 8 && smy < 4))        n++;
    if (sls  !== sls_e)                       n++;
    if (sfs  !== sfs_e)                       n++;
    return n;
  endfunction

  task automatic do_reset_release();
    rst = 1'b1; pix_en = 1'b0; model_reset();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    logic [15:0] fc_exp;
    rst = 1'b1; pix_en = 1'b0; model_reset();
    repeat (2) tick();
    checks++; if ({x, y} !== {16'd1687, 16'd1065}) begin errors++; $display("FAIL reset_xy: got %0d,%0d expected 1687,1065", x, y); end
    checks++; if ({hs, vs, act, ls, fs} !== 5'b00000) begin errors++; $display("FAIL reset_flags: got %b expected 00000", {hs, vs, act, ls, fs}); end
    checks++; if (fc !== 16'd0) begin errors++; $display("FAIL reset_fc: got %0d expected 0", fc); end
    checks++; if ({sx, sy} !== {16'd15, 16'd8}) begin errors++; $display("FAIL reset_small_xy: got %0d,%0d expected 15,8", sx, sy); end
    checks++; if ({shs, svs, sact, sls, sfs} !== 5'b11000) begin errors++; $display("FAIL reset_small_flags: got %b expected 11000", {shs, svs, sact, sls, sfs}); end
    rst = 1'b0;
    tick();
    checks++; if ({x, y, sx, sy} !== {16'd1687, 16'd1065, 16'd15, 16'd8}) begin errors++; $display("FAIL release_hold: got %0d,%0d %0d,%0d", x, y, sx, sy); end
    pix_en = 1'b1;
    tick();
    checks++; if ({x, y} !== 32'd0) begin errors++; $display("FAIL first_xy: got %0d,%0d expected 0,0", x, y); end
    checks++; if ({hs, vs, act, ls, fs} !== 5'b00111) begin errors++; $display("FAIL first_flags: got %b expected 00111", {hs, vs, act, ls, fs}); end
    checks++; if ({sx, sy} !== 32'd0) begin errors++; $display("FAIL first_small_xy: got %0d,%0d expected 0,0", sx, sy); end
    checks++; if ({shs, svs, sact, sls, sfs} !== 5'b11111) begin errors++; $display("FAIL first_small_flags: got %b expected 11111", {shs, svs, sact, sls, sfs}); end
`ifdef VGA_TIMING_FRAME_CNT_EN
    fc_exp = 16'd1;
`else
    fc_exp = 16'd0;
`endif
    checks++; if (fc !== fc_exp) begin errors++; $display("FAIL first_fc: got %0d expected %0d", fc, fc_exp); end
  endtask

  task automatic test_line();
    int nbad = 0;
    int hs_cnt = 0;
    do_reset_release();
    pix_en = 1'b1;
    tick();
    for (int i = 0; i < 1688; i++) begin
      tick();
      nbad += mism();
      if (hs === 1'b1) hs_cnt++;
      if (bx == 1279) begin checks++; if (act !== 1'b1) begin errors++; $display("FAIL act_1279: got %b expected 1", act); end end
      if (bx == 1280) begin checks++; if (act !== 1'b0) begin errors++; $display("FAIL act_1280: got %b expected 0", act); end end
      if (bx == 1327) begin checks++; if (hs !== 1'b0) begin errors++; $display("FAIL hs_1327: got %b expected 0", hs); end end
      if (bx == 1328) begin checks++; if (hs !== 1'b1) begin errors++; $display("FAIL hs_1328: got %b expected 1", hs); end end
      if (bx == 1439) begin checks++; if (hs !== 1'b1) begin errors++; $display("FAIL hs_1439: got %b expected 1", hs); end end
      if (bx == 1440) begin checks++; if (hs !== 1'b0) begin errors++; $display("FAIL hs_1440: got %b expected 0", hs); end end
    end
    checks++; if ({x, y, ls} !== {16'd0, 16'd1, 1'b1}) begin errors++; $display("FAIL line_wrap: got x=%0d y=%0d ls=%b expected 0,1,1", x, y, ls); end
    checks++; if (hs_cnt != 112) begin errors++; $display("FAIL hs_width: got %0d expected 112", hs_cnt); end
    checks++; if (nbad != 0) begin errors++; $display("FAIL line_sweep: got %0d mismatches expected 0", nbad); end
  endtask

  task automatic test_frame();
    int nbad = 0, last = -1, fs_n = 0, edge_bad = 0;
    logic prev_svs;
    do_reset_release();
    pix_en = 1'b1;
    prev_svs = svs;
    for (int cyc = 0; cyc <= 3 * 144; cyc++) begin
      tick();
      nbad += mism();
      if (sfs === 1'b1) begin
        if (last >= 0) begin
          checks++; if (cyc - last != 144) begin errors++; $display("FAIL fs_period: got %0d expected 144", cyc - last); end
        end
        last = cyc;
        fs_n++;
      end
      if (svs !== prev_svs) begin
        if (sx !== 16'd0) edge_bad++;
        if (svs === 1'b0) begin
          checks++; if ({sx, sy} !== {16'd0, 16'd5}) begin errors++; $display("FAIL vs_assert_pos: got %0d,%0d expected 0,5", sx, sy); end
        end
      end
      prev_svs = svs;
    end
    checks++; if (fs_n != 4) begin errors++; $display("FAIL fs_count: got %0d expected 4", fs_n); end
    checks++; if (edge_bad != 0) begin errors++; $display("FAIL vs_edge_x0: got %0d off-x0 edges expected 0", edge_bad); end
    checks++; if (nbad != 0) begin errors++; $display("FAIL frame_sweep: got %0d mismatches expected 0", nbad); end
  endtask

  task automatic test_pix_en_toggle();
    int nbad = 0, last = -1, fs_n = 0, wide = 0;
    logic prev_fs = 1'b0, prev_ls = 1'b0;
    do_reset_release();
    for (int i = 0; i <= 2 * 288; i++) begin
      pix_en = (i % 2 == 0);
      tick();
      nbad += mism();
      if (sfs === 1'b1) begin
        if (last >= 0) begin
          checks++; if (i - last != 288) begin errors++; $display("FAIL fs_period_half: got %0d expected 288", i - last); end
        end
        last = i;
        fs_n++;
      end
      if ((sfs === 1'b1 && prev_fs === 1'b1) || (sls === 1'b1 && prev_ls === 1'b1)) wide++;
      prev_fs = sfs;
      prev_ls = sls;
    end
    pix_en = 1'b1;
    checks++; if (fs_n != 3) begin errors++; $display("FAIL fs_count_half: got %0d expected 3", fs_n); end
    checks++; if (wide != 0) begin errors++; $display("FAIL strobe_width: got %0d wide strobes expected 0", wide); end
    checks++; if (nbad != 0) begin errors++; $display("FAIL toggle_sweep: got %0d mismatches expected 0", nbad); end
  endtask

  task automatic test_mid_reset();
    int nbad = 0, vs_cnt = 0;
    do_reset_release();
    pix_en = 1'b1;
    tick();
    repeat (700) begin tick(); nbad += mism(); end
    checks++; if ({x, y} !== {16'd700, 16'd0}) begin errors++; $display("FAIL pre_reset_pos: got %0d,%0d expected 700,0", x, y); end
    #2 rst = 1'b1; model_reset();
    #1;
    checks++; if ({x, y, hs, vs, act, ls, fs} !== {16'd1687, 16'd1065, 5'b00000}) begin errors++; $display("FAIL mid_reset_big: got %0d,%0d %b", x, y, {hs, vs, act, ls, fs}); end
    checks++; if ({sx, sy, shs, svs, sact, sls, sfs} !== {16'd15, 16'd8, 5'b11000}) begin errors++; $display("FAIL mid_reset_small: got %0d,%0d %b", sx, sy, {shs, svs, sact, sls, sfs}); end
    tick();
    rst = 1'b0;
    tick();
    checks++; if ({x, y, hs, vs, act, ls, fs} !== {32'd0, 5'b00111}) begin errors++; $display("FAIL restart_big: got %0d,%0d %b", x, y, {hs, vs, act, ls, fs}); end
    checks++; if ({sx, sy, shs, svs, sact, sls, sfs} !== {32'd0, 5'b11111}) begin errors++; $display("FAIL restart_small: got %0d,%0d %b", sx, sy, {shs, svs, sact, sls, sfs}); end
    repeat (85) begin tick(); nbad += mism(); end
    checks++; if ({sx, sy, svs} !== {16'd5, 16'd5, 1'b0}) begin errors++; $display("FAIL in_vsync: got %0d,%0d vs=%b expected 5,5,0", sx, sy, svs); end
    #2 rst = 1'b1; model_reset();
    #1;
    checks++; if ({sx, sy, shs, svs} !== {16'd15, 16'd8, 2'b11}) begin errors++; $display("FAIL vsync_reset: got %0d,%0d hs=%b vs=%b", sx, sy, shs, svs); end
    tick();
    rst = 1'b0;
    repeat (145) begin
      tick();
      nbad += mism();
      if (svs === 1'b0) vs_cnt++;
    end
    checks++; if (vs_cnt != 32) begin errors++; $display("FAIL vs_len_after_reset: got %0d expected 32", vs_cnt); end
    checks++; if (nbad != 0) begin errors++; $display("FAIL mid_reset_sweep: got %0d mismatches expected 0", nbad); end
  endtask

  task automatic test_frame_count();
`ifdef VGA_TIMING_FRAME_CNT_EN
    int n = 0;
    logic seen = 1'b0;
    do_reset_release();
    pix_en = 1'b1;
    for (int i = 0; i < 600 && n < 3; i++) begin
      tick();
      if (sfs === 1'b1) begin
        n++;
        checks++; if (sfc !== 16'(n)) begin errors++; $display("FAIL fc_seq: got %0d expected %0d", sfc, n); end
      end
    end
    checks++; if (n != 3) begin errors++; $display("FAIL fc_timeout: got %0d frames expected 3", n); end
    force u_small.frame_cnt = 16'hFFFF;
    tick();
    release u_small.frame_cnt;
    tick();
    checks++; if (sfc !== 16'hFFFF) begin errors++; $display("FAIL fc_preload: got %0d expected 65535", sfc); end
    for (int i = 0; i < 200 && !seen; i++) begin
      tick();
      if (sfs === 1'b1) seen = 1'b1;
    end
    checks++; if (!seen || sfc !== 16'd0) begin errors++; $display("FAIL fc_wrap: got %0d (seen=%b) expected 0", sfc, seen); end
`else
    int nz = 0;
    do_reset_release();
    pix_en = 1'b1;
    repeat (300) begin
      tick();
      if (fc !== 16'd0 || sfc !== 16'd0) nz++;
    end
    checks++; if (nz != 0) begin errors++; $display("FAIL fc_tied: got %0d nonzero samples expected 0", nz); end
`endif
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    pix_en = 1'b0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_line();
    test_frame();
    test_pix_en_toggle();
    test_mid_reset();
    test_frame_count();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
